// File: rtl/regfile_bram_ctrl_if.sv
// Core-side and BRAM-side signal bundle of the register-file BRAM controller.
// slave = controller view, master = core/BRAM environment view.
interface regfile_bram_ctrl_if #(
   parameter int DTW = 32,
   parameter int ADW = 5
);
   logic           i_rden;
   logic [ADW-1:0] i_raddr0;
   logic [ADW-1:0] i_raddr1;
   logic [DTW-1:0] o_rdata0;
   logic [DTW-1:0] o_rdata1;
   logic           i_wren;
   logic [ADW-1:0] i_waddr;
   logic [DTW-1:0] i_wdata;
   logic           o_init_busy;
   logic           o_init_done;
   logic           o_bram_wren;
   logic [ADW-1:0] o_bram_waddr;
   logic [DTW-1:0] o_bram_wdata;
   logic           o_bram_rden0;
   logic [ADW-1:0] o_bram_raddr0;
   logic           o_bram_rden1;
   logic [ADW-1:0] o_bram_raddr1;
   logic [DTW-1:0] i_bram_rdata0;
   logic [DTW-1:0] i_bram_rdata1;

   modport slave (
      input  i_rden, i_raddr0, i_raddr1, i_wren, i_waddr, i_wdata,
             i_bram_rdata0, i_bram_rdata1,
      output o_rdata0, o_rdata1, o_init_busy, o_init_done,
             o_bram_wren, o_bram_waddr, o_bram_wdata,
             o_bram_rden0, o_bram_raddr0, o_bram_rden1, o_bram_raddr1
   );

   modport master (
      output i_rden, i_raddr0, i_raddr1, i_wren, i_waddr, i_wdata,
             i_bram_rdata0, i_bram_rdata1,
      input  o_rdata0, o_rdata1, o_init_busy, o_init_done,
             o_bram_wren, o_bram_waddr, o_bram_wdata,
             o_bram_rden0, o_bram_raddr0, o_bram_rden1, o_bram_raddr1
   );
endinterface

// File: rtl/regfile_bram_ctrl.sv
// 2R/1W register file sequencer over an external 1-cycle BRAM: post-reset clear,
// same-cycle write-to-read forwarding and hard-wired x0.
module regfile_rd_port #(
   parameter int DTW     = 32,
   parameter int ADW     = 5,
   parameter int ZERO_R0 = 1
) (
   input  logic           clk,
   input  logic           aresetn,
   input  logic           rd_en,
   input  logic [ADW-1:0] raddr,
   input  logic           wr_en,
   input  logic [ADW-1:0] waddr,
   input  logic [DTW-1:0] wdata,
   input  logic [DTW-1:0] bram_rdata,
   output logic [DTW-1:0] rdata
);
   logic           vld;
   logic           zero;
   logic           byp;
   logic [DTW-1:0] bypd;

   // vld masks the BRAM output until this port has issued its first read.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         vld  <= 1'b0;
         zero <= 1'b0;
         byp  <= 1'b0;
         bypd <= '0;
      end else if (rd_en) begin
         vld  <= 1'b1;
         zero <= (ZERO_R0 != 0) && (raddr == '0);
         byp  <= wr_en && (waddr == raddr);
         bypd <= wdata;
      end
   end

   assign rdata = (!vld || zero) ? '0 : (byp ? bypd : bram_rdata);
endmodule

module regfile_bram_ctrl #(
   parameter int             DTW      = 32,
   parameter int             DPT      = 32,
   parameter int             INIT_EN  = 1,
   parameter logic [DTW-1:0] INIT_VAL = '0,
   parameter int             ZERO_R0  = 1
) (
   input  logic                clk,
   input  logic                aresetn,
   regfile_bram_ctrl_if.slave  bus
);
   localparam int             ADW      = $clog2(DPT);
   localparam int             DPT_2N   = 2 ** ADW;
   localparam logic [ADW-1:0] CNT_LAST = ADW'(DPT_2N - 1);
   localparam int             NRP      = 2;

   typedef enum logic [1:0] {RST_WAIT, CLEAR, RUN} state_t;

   state_t         state;
   logic [ADW-1:0] clr_cnt;
   logic           busy;
   logic           done;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= RST_WAIT;
         clr_cnt <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            RST_WAIT: begin
               if (INIT_EN != 0) begin
                  state <= CLEAR;
               end else begin
                  state <= RUN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CNT_LAST) begin
                  state <= RUN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_init_busy = busy;
   assign bus.o_init_done = done;

   logic run;
   logic eff_wren;
   logic rd_en;

   assign run      = (state == RUN);
   assign eff_wren = run && bus.i_wren && !((ZERO_R0 != 0) && (bus.i_waddr == '0));
   assign rd_en    = run && bus.i_rden;

   // The clear sequence owns the write port; core traffic only reaches it in RUN.
   always_comb begin
      bus.o_bram_wren  = eff_wren;
      bus.o_bram_waddr = bus.i_waddr;
      bus.o_bram_wdata = bus.i_wdata;
      if (state == CLEAR) begin
         bus.o_bram_wren  = 1'b1;
         bus.o_bram_waddr = clr_cnt;
         bus.o_bram_wdata = INIT_VAL;
      end
   end

   assign bus.o_bram_rden0  = rd_en;
   assign bus.o_bram_rden1  = rd_en;
   assign bus.o_bram_raddr0 = bus.i_raddr0;
   assign bus.o_bram_raddr1 = bus.i_raddr1;

   logic [NRP-1:0][ADW-1:0] raddr;
   logic [NRP-1:0][DTW-1:0] brd;
   logic [NRP-1:0][DTW-1:0] rdata;

   assign raddr = {bus.i_raddr1, bus.i_raddr0};
   assign brd   = {bus.i_bram_rdata1, bus.i_bram_rdata0};

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      regfile_rd_port #(.DTW(DTW), .ADW(ADW), .ZERO_R0(ZERO_R0)) u_rd (
         .clk        (clk),
         .aresetn    (aresetn),
         .rd_en      (rd_en),
         .raddr      (raddr[p]),
         .wr_en      (eff_wren),
         .waddr      (bus.i_waddr),
         .wdata      (bus.i_wdata),
         .bram_rdata (brd[p]),
         .rdata      (rdata[p])
      );
   end

   assign bus.o_rdata0 = rdata[0];
   assign bus.o_rdata1 = rdata[1];
endmodule

// File: tb/tb_regfile_bram_ctrl.sv
// Directed bench for regfile_bram_ctrl with a behavioural 1-cycle BRAM (old data on
// read-during-write) and a second INIT_EN=0 instance.
module tb_regfile_bram_ctrl;
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   regfile_bram_ctrl_if #(.DTW(32), .ADW(5)) bus ();
   regfile_bram_ctrl_if #(.DTW(32), .ADW(5)) bus2 ();

   regfile_bram_ctrl #(.DTW(32), .DPT(32), .INIT_EN(1), .INIT_VAL(32'h0), .ZERO_R0(1)) dut (
      .clk(clk), .aresetn(aresetn), .bus(bus));
   regfile_bram_ctrl #(.DTW(32), .DPT(32), .INIT_EN(0), .INIT_VAL(32'h0), .ZERO_R0(1)) dut_ni (
      .clk(clk), .aresetn(aresetn), .bus(bus2));

   logic [31:0] mem [0:31];
   logic        fill = 1'b0;
   logic        poke = 1'b0;
   logic [4:0]  poke_addr = '0;
   logic [31:0] poke_data = '0;

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE0000 + i;
      end else if (poke) begin
         mem[poke_addr] <= poke_data;
      end else if (bus.o_bram_wren) begin
         mem[bus.o_bram_waddr] <= bus.o_bram_wdata;
      end
      if (bus.o_bram_rden0) bus.i_bram_rdata0 <= mem[bus.o_bram_raddr0];
      if (bus.o_bram_rden1) bus.i_bram_rdata1 <= mem[bus.o_bram_raddr1];
   end

   task automatic idle();
      bus.i_rden = 0; bus.i_raddr0 = '0; bus.i_raddr1 = '0;
      bus.i_wren = 0; bus.i_waddr = '0;  bus.i_wdata = '0;
   endtask

   // Walks a clear sequence from the release edge, counting cycles and ordered writes.
   task automatic run_init(output int cyc_n, output int wr_n, output int bad);
      cyc_n = 0; wr_n = 0; bad = 0;
      while (bus.o_init_busy && cyc_n < 100) begin
         if (bus.o_bram_rden0 || bus.o_bram_rden1) bad++;
         if (bus.o_bram_wren) begin
            if (bus.o_bram_waddr != 5'(wr_n) || bus.o_bram_wdata != 32'h0) bad++;
            wr_n++;
         end
         @(negedge clk);
         cyc_n++;
      end
   endtask

   task automatic test_reset();
      int c, w, e, nz;
      bus.i_rden = 1; bus.i_raddr0 = 5'd4; bus.i_raddr1 = 5'd6;
      bus.i_wren = 1; bus.i_waddr = 5'd9; bus.i_wdata = 32'hFFFF_FFFF;
      fill = 1; aresetn = 0;
      repeat (2) @(negedge clk);
      fill = 0;
      n_cmp++; if (bus.o_init_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", bus.o_init_busy); end
      n_cmp++; if (bus.o_init_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.o_init_done); end
      n_cmp++; if (bus.o_rdata0 !== 32'h0 || bus.o_rdata1 !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.o_rdata0, bus.o_rdata1); end
      n_cmp++; if (bus.o_bram_wren !== 1'b0 || bus.o_bram_rden0 !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got wren %b rden0 %b want 0/0", bus.o_bram_wren, bus.o_bram_rden0); end
      aresetn = 1;
      run_init(c, w, e);
      idle();
      n_cmp++; if (c !== 33) begin n_err++; $display("FAIL init_busy_cycles: got %0d want 33", c); end
      n_cmp++; if (w !== 32) begin n_err++; $display("FAIL init_writes: got %0d want 32", w); end
      n_cmp++; if (e !== 0) begin n_err++; $display("FAIL init_order: got %0d bad cycles want 0", e); end
      n_cmp++; if (bus.o_init_done !== 1'b1 || bus.o_init_busy !== 1'b0) begin n_err++; $display("FAIL init_done: got done %b busy %b want 1/0", bus.o_init_done, bus.o_init_busy); end
      @(negedge clk);
      nz = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== 32'h0) nz++;
      n_cmp++; if (nz !== 0) begin n_err++; $display("FAIL init_mem_clear: got %0d nonzero entries want 0", nz); end
   endtask

   task automatic test_write_read();
      bus.i_wren = 1; bus.i_waddr = 5'd5; bus.i_wdata = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (bus.o_bram_wren !== 1'b1 || bus.o_bram_waddr !== 5'd5 || bus.o_bram_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_pass: got %b %h %h want 1 05 deadbeef", bus.o_bram_wren, bus.o_bram_waddr, bus.o_bram_wdata); end
      @(negedge clk);
      bus.i_wren = 0; bus.i_rden = 1; bus.i_raddr0 = 5'd5; bus.i_raddr1 = 5'd2;
      #1;
      n_cmp++; if (bus.o_bram_rden0 !== 1'b1 || bus.o_bram_raddr0 !== 5'd5) begin n_err++; $display("FAIL rd_pass: got %b %h want 1 05", bus.o_bram_rden0, bus.o_bram_raddr0); end
      @(negedge clk);
      idle();
      n_cmp++; if (bus.o_rdata0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_then_rd: got %h want deadbeef", bus.o_rdata0); end
      n_cmp++; if (bus.o_rdata1 !== 32'h0) begin n_err++; $display("FAIL rd_cleared: got %h want 0", bus.o_rdata1); end
      n_cmp++; if (dut.g_rd[0].u_rd.byp !== 1'b0) begin n_err++; $display("FAIL wr_then_rd_byp: got %b want 0", dut.g_rd[0].u_rd.byp); end
   endtask

   task automatic test_bypass();
      bus.i_wren = 1; bus.i_waddr = 5'd7; bus.i_wdata = 32'h1234_5678;
      bus.i_rden = 1; bus.i_raddr0 = 5'd7; bus.i_raddr1 = 5'd7;
      @(negedge clk);
      idle();
      n_cmp++; if (bus.o_rdata0 !== 32'h1234_5678) begin n_err++; $display("FAIL byp_port0: got %h want 12345678", bus.o_rdata0); end
      n_cmp++; if (bus.o_rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL byp_port1: got %h want 12345678", bus.o_rdata1); end
   endtask

   task automatic test_zero();
      poke = 1; poke_addr = 5'd0; poke_data = 32'hBAD0_BAD0;
      bus.i_wren = 1; bus.i_waddr = 5'd0; bus.i_wdata = 32'hFFFF_FFFF;
      #1;
      n_cmp++; if (bus.o_bram_wren !== 1'b0) begin n_err++; $display("FAIL x0_wr_drop: got %b want 0", bus.o_bram_wren); end
      @(negedge clk);
      poke = 0;
      bus.i_wren = 1; bus.i_waddr = 5'd0; bus.i_wdata = 32'h0BAD_F00D;
      bus.i_rden = 1; bus.i_raddr0 = 5'd7; bus.i_raddr1 = 5'd0;
      @(negedge clk);
      idle();
      n_cmp++; if (bus.o_rdata1 !== 32'h0) begin n_err++; $display("FAIL x0_read: got %h want 0", bus.o_rdata1); end
      n_cmp++; if (bus.o_rdata0 !== 32'h1234_5678) begin n_err++; $display("FAIL x7_from_bram: got %h want 12345678", bus.o_rdata0); end
   endtask

   task automatic test_hold();
      bus.i_wren = 1; bus.i_waddr = 5'd3; bus.i_wdata = 32'hA5;
      @(negedge clk);
      bus.i_wren = 0; bus.i_rden = 1; bus.i_raddr0 = 5'd3;
      @(negedge clk);
      bus.i_rden = 0;
      n_cmp++; if (bus.o_rdata0 !== 32'hA5) begin n_err++; $display("FAIL hold_first: got %h want a5", bus.o_rdata0); end
      for (int k = 0; k < 3; k++) begin
         bus.i_wren = 1; bus.i_waddr = 5'd3; bus.i_wdata = 32'h5A;
         @(negedge clk);
         n_cmp++; if (bus.o_rdata0 !== 32'hA5) begin n_err++; $display("FAIL hold_cycle%0d: got %h want a5", k, bus.o_rdata0); end
      end
      bus.i_wren = 0; bus.i_rden = 1;
      @(negedge clk);
      idle();
      n_cmp++; if (bus.o_rdata0 !== 32'h5A) begin n_err++; $display("FAIL hold_reread: got %h want 5a", bus.o_rdata0); end
   endtask

   task automatic test_mid_clear();
      int c, w, e, n;
      aresetn = 0;
      @(negedge clk);
      aresetn = 1;
      n = 0;
      while (!(bus.o_bram_wren && bus.o_bram_waddr == 5'd10) && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (n >= 100) begin n_err++; $display("FAIL mid_clear_reach: got timeout want clr_cnt 10"); end
      #2 aresetn = 0;
      #1;
      n_cmp++; if (bus.o_init_busy !== 1'b1 || bus.o_bram_wren !== 1'b0 || bus.o_init_done !== 1'b0) begin n_err++; $display("FAIL mid_clear_abort: got busy %b wren %b done %b want 1 0 0", bus.o_init_busy, bus.o_bram_wren, bus.o_init_done); end
      @(negedge clk);
      aresetn = 1;
      run_init(c, w, e);
      n_cmp++; if (c !== 33 || w !== 32 || e !== 0) begin n_err++; $display("FAIL reclear: got cyc %0d wr %0d bad %0d want 33 32 0", c, w, e); end
      n_cmp++; if (bus.o_init_done !== 1'b1) begin n_err++; $display("FAIL reclear_done: got %b want 1", bus.o_init_done); end
   endtask

   task automatic test_no_init();
      aresetn = 0;
      @(negedge clk);
      n_cmp++; if (bus2.o_init_busy !== 1'b1 || bus2.o_init_done !== 1'b0) begin n_err++; $display("FAIL ni_rst: got busy %b done %b want 1 0", bus2.o_init_busy, bus2.o_init_done); end
      aresetn = 1;
      #1;
      n_cmp++; if (bus2.o_init_busy !== 1'b1 || bus2.o_bram_wren !== 1'b0) begin n_err++; $display("FAIL ni_wait: got busy %b wren %b want 1 0", bus2.o_init_busy, bus2.o_bram_wren); end
      @(negedge clk);
      n_cmp++; if (bus2.o_init_busy !== 1'b0 || bus2.o_init_done !== 1'b1) begin n_err++; $display("FAIL ni_run: got busy %b done %b want 0 1", bus2.o_init_busy, bus2.o_init_done); end
      n_cmp++; if (bus.o_init_busy !== 1'b1) begin n_err++; $display("FAIL ni_vs_init: got busy %b want 1", bus.o_init_busy); end
   endtask

   initial begin
      bus2.i_rden = 0; bus2.i_raddr0 = '0; bus2.i_raddr1 = '0;
      bus2.i_wren = 0; bus2.i_waddr = '0;  bus2.i_wdata = '0;
      bus2.i_bram_rdata0 = '0; bus2.i_bram_rdata1 = '0;
      idle();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_bypass();
      test_zero();
      test_hold();
      test_mid_clear();
      test_no_init();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
